// File: rtl/mem_integrity_checker.sv
// Passive shadow-table monitor: remembers recent writes and checks read data RD_LAT cycles later.
// Define MEM_CHK_ASSERT_EN to embed SVA checks; outputs are identical either way.
module mem_integrity_checker #(
  parameter int DW      = 32,
  parameter int AW      = 32,
  parameter int ENTRIES = 8,
  parameter int RD_LAT  = 1,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             write,
  input  logic             read,
  input  logic [AW-1:0]    addr,
  input  logic [DW-1:0]    wdata,
  input  logic [DW-1:0]    rdata,
  input  logic             clear,
  output logic             err_pulse,
  output logic             err_sticky,
  output logic [AW-1:0]    err_addr,
  output logic [DW-1:0]    err_exp,
  output logic [DW-1:0]    err_got,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] chk_cnt,
  output logic             table_full
);
  localparam int IW = $clog2(ENTRIES);

  logic [ENTRIES-1:0]          r_vld;
  logic [ENTRIES-1:0][AW-1:0]  r_tag;
  logic [ENTRIES-1:0][DW-1:0]  r_dat;
  logic [IW-1:0]               r_rr;
  logic                        r_full;

  logic [RD_LAT-1:0]           r_vld_pipe;
  logic [RD_LAT-1:0][AW-1:0]   r_addr_pipe;
  logic [RD_LAT-1:0][DW-1:0]   r_exp_pipe;

  logic                        r_pulse;
  logic                        r_sticky;
  logic [AW-1:0]               r_eaddr;
  logic [DW-1:0]               r_eexp;
  logic [DW-1:0]               r_egot;
  logic [CNT_W-1:0]            r_err;
  logic [CNT_W-1:0]            r_chk;

  logic                        w_hit, w_free, w_chk, w_mis;
  logic [IW-1:0]               w_hidx, w_fidx, w_widx;
  logic [DW-1:0]               w_exp;
  logic [ENTRIES-1:0]          w_vld_nxt;

  // Descending scan so the lowest matching / lowest free index wins.
  always_comb begin
    w_hit  = 1'b0;
    w_hidx = '0;
    w_free = 1'b0;
    w_fidx = '0;
    for (int i = ENTRIES-1; i >= 0; i--) begin
      if (r_vld[i] && (r_tag[i] == addr)) begin
        w_hit  = 1'b1;
        w_hidx = IW'(i);
      end
      if (!r_vld[i]) begin
        w_free = 1'b1;
        w_fidx = IW'(i);
      end
    end
  end

  assign w_exp     = r_dat[w_hidx];
  assign w_widx    = w_hit ? w_hidx : (w_free ? w_fidx : r_rr);
  assign w_vld_nxt = r_vld | (write ? (ENTRIES'(1) << w_widx) : '0);
  assign w_chk     = r_vld_pipe[RD_LAT-1];
  assign w_mis     = w_chk && (rdata != r_exp_pipe[RD_LAT-1]);

  // Table is registered, so a same-cycle read naturally sees pre-write data.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_vld  <= '0;
      r_tag  <= '0;
      r_dat  <= '0;
      r_rr   <= '0;
      r_full <= 1'b0;
    end else begin
      if (write) begin
        r_vld[w_widx] <= 1'b1;
        r_tag[w_widx] <= addr;
        r_dat[w_widx] <= wdata;
        if (!w_hit && !w_free) r_rr <= r_rr + IW'(1);
      end
      r_full <= &w_vld_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_vld_pipe  <= '0;
      r_addr_pipe <= '0;
      r_exp_pipe  <= '0;
    end else begin
      r_vld_pipe[0]  <= read && w_hit;
      r_addr_pipe[0] <= addr;
      r_exp_pipe[0]  <= w_exp;
      for (int i = 1; i < RD_LAT; i++) begin
        r_vld_pipe[i]  <= r_vld_pipe[i-1];
        r_addr_pipe[i] <= r_addr_pipe[i-1];
        r_exp_pipe[i]  <= r_exp_pipe[i-1];
      end
    end
  end

  // clear beats a coincident mismatch for counters/capture, but the pulse still fires.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pulse  <= 1'b0;
      r_sticky <= 1'b0;
      r_eaddr  <= '0;
      r_eexp   <= '0;
      r_egot   <= '0;
      r_err    <= '0;
      r_chk    <= '0;
    end else begin
      r_pulse <= w_mis;
      if (clear) begin
        r_sticky <= 1'b0;
        r_eaddr  <= '0;
        r_eexp   <= '0;
        r_egot   <= '0;
        r_err    <= '0;
        r_chk    <= '0;
      end else begin
        if (w_chk && (r_chk != '1)) r_chk <= r_chk + CNT_W'(1);
        if (w_mis) begin
          if (r_err != '1) r_err <= r_err + CNT_W'(1);
          if (!r_sticky) begin
            r_sticky <= 1'b1;
            r_eaddr  <= r_addr_pipe[RD_LAT-1];
            r_eexp   <= r_exp_pipe[RD_LAT-1];
            r_egot   <= rdata;
          end
        end
      end
    end
  end

  assign err_pulse  = r_pulse;
  assign err_sticky = r_sticky;
  assign err_addr   = r_eaddr;
  assign err_exp    = r_eexp;
  assign err_got    = r_egot;
  assign err_cnt    = r_err;
  assign chk_cnt    = r_chk;
  assign table_full = r_full;

`ifdef MEM_CHK_ASSERT_EN
  ap_data_match: assert property (@(posedge clk) disable iff (!reset_n)
    w_chk |-> (rdata == r_exp_pipe[RD_LAT-1]))
    else $error("data mismatch addr=%h exp=%h got=%h",
                r_addr_pipe[RD_LAT-1], r_exp_pipe[RD_LAT-1], rdata);
  ap_no_x_rdata: assert property (@(posedge clk) disable iff (!reset_n)
    w_chk |-> !$isunknown(rdata));
  ap_no_rw_x: assert property (@(posedge clk) disable iff (!reset_n)
    !$isunknown({write, read}));
`endif
endmodule

// File: tb/tb_mem_integrity_checker.sv
// Directed bench for mem_integrity_checker (ENTRIES=8, RD_LAT=3, CNT_W=4 so saturation is reachable).
module tb_mem_integrity_checker;
  localparam int DW = 32, AW = 32, ENTRIES = 8, RD_LAT = 3, CNT_W = 4;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             write = 1'b0, read = 1'b0, clear = 1'b0;
  logic [AW-1:0]    addr = '0;
  logic [DW-1:0]    wdata = '0, rdata = '0;
  logic             err_pulse, err_sticky, table_full;
  logic [AW-1:0]    err_addr;
  logic [DW-1:0]    err_exp, err_got;
  logic [CNT_W-1:0] err_cnt, chk_cnt;

  int n_tot = 0;
  int n_bad = 0;

  mem_integrity_checker #(.DW(DW), .AW(AW), .ENTRIES(ENTRIES), .RD_LAT(RD_LAT), .CNT_W(CNT_W)) u_dut (
    .clk(clk), .reset_n(reset_n), .write(write), .read(read), .addr(addr),
    .wdata(wdata), .rdata(rdata), .clear(clear), .err_pulse(err_pulse),
    .err_sticky(err_sticky), .err_addr(err_addr), .err_exp(err_exp), .err_got(err_got),
    .err_cnt(err_cnt), .chk_cnt(chk_cnt), .table_full(table_full));

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    write = 1'b1; addr = a; wdata = d;
    step();
    write = 1'b0;
  endtask

  // Read request, then present rdata on the edge RD_LAT cycles later; returns the pulse seen after it.
  task automatic rd(input logic [AW-1:0] a, input logic [DW-1:0] d, output logic pulse);
    read = 1'b1; addr = a;
    step();
    read = 1'b0;
    repeat (RD_LAT-1) step();
    rdata = d;
    step();
    pulse = err_pulse;
    rdata = '0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
  endtask

  logic p;

  initial begin
    step(); step();
    chk("rst_pulse", err_pulse, 0);
    chk("rst_sticky", err_sticky, 0);
    chk("rst_cnts", {err_cnt, chk_cnt}, 0);
    chk("rst_capture", {err_addr, err_exp, err_got}, 0);
    chk("rst_full", table_full, 0);
    reset_n = 1'b1;
    step();

    // 1: clean check
    wr(32'h10, 32'hCAFE);
    rd(32'h10, 32'hCAFE, p);
    chk("t1_pulse", p, 0);
    chk("t1_chk", chk_cnt, 1);
    chk("t1_err", err_cnt, 0);
    chk("t1_sticky", err_sticky, 0);

    // 2: mismatch + first-error capture
    wr(32'h20, 32'h1234);
    rd(32'h20, 32'h1235, p);
    chk("t2_pulse", p, 1);
    step();
    chk("t2_pulse_1cyc", err_pulse, 0);
    chk("t2_sticky", err_sticky, 1);
    chk("t2_addr", err_addr, 32'h20);
    chk("t2_exp", err_exp, 32'h1234);
    chk("t2_got", err_got, 32'h1235);
    chk("t2_err", err_cnt, 1);
    chk("t2_chk", chk_cnt, 2);
    wr(32'h30, 32'h55);
    rd(32'h30, 32'h56, p);
    chk("t2b_pulse", p, 1);
    chk("t2b_err", err_cnt, 2);
    chk("t2b_addr_kept", err_addr, 32'h20);
    chk("t2b_got_kept", err_got, 32'h1235);
    chk("t2b_full", table_full, 0);
    do_clear();
    chk("clr_cnts", {err_cnt, chk_cnt}, 0);
    chk("clr_sticky", err_sticky, 0);
    chk("clr_capture", {err_addr, err_exp, err_got}, 0);

    // 3: fill (entries 3..7), evict in round-robin order
    for (int i = 0; i < 4; i++) wr(32'h100 + i, 32'h500 + i);
    chk("t3_not_full", table_full, 0);
    wr(32'h104, 32'h504);
    chk("t3_full", table_full, 1);
    wr(32'h200, 32'h9999);          // evicts 0x10 (entry 0)
    rd(32'h10, 32'hBAD, p);
    chk("t3_evict_pulse", p, 0);
    chk("t3_evict_chk", chk_cnt, 0);
    rd(32'h200, 32'h9999, p);
    chk("t3_new_chk", chk_cnt, 1);
    wr(32'h300, 32'h7);             // evicts 0x20 (entry 1)
    rd(32'h20, 32'hBAD, p);
    chk("t3_rr_evict", chk_cnt, 1);
    rd(32'h30, 32'h55, p);
    chk("t3_survivor", chk_cnt, 2);
    wr(32'h30, 32'h77);             // hit: update in place
    rd(32'h30, 32'h77, p);
    chk("t3_update", {p, err_cnt, chk_cnt}, {1'b0, 4'd0, 4'd3});
    chk("t3_still_full", table_full, 1);

    // 4: same-cycle write+read sees old data
    wr(32'h40, 32'hA);              // evicts 0x30 (entry 2)
    write = 1'b1; read = 1'b1; addr = 32'h40; wdata = 32'hB;
    step();
    write = 1'b0; read = 1'b0;
    repeat (RD_LAT-1) step();
    rdata = 32'hA;
    step();
    rdata = '0;
    chk("t4_rw_pulse", err_pulse, 0);
    chk("t4_rw_cnt", {err_cnt, chk_cnt}, {4'd0, 4'd4});
    rd(32'h40, 32'hB, p);
    chk("t4_new_val", {p, err_cnt}, {1'b0, 4'd0});
    rd(32'h40, 32'hA, p);
    chk("t4_old_val_err", {p, err_cnt}, {1'b1, 4'd1});

    // 5: saturation, then clear coincident with a mismatch
    do_clear();
    for (int i = 0; i < 20; i++) rd(32'h40, 32'h0, p);
    chk("t5_err_sat", err_cnt, 15);
    chk("t5_chk_sat", chk_cnt, 15);
    chk("t5_capture", {err_sticky, err_addr, err_exp}, {1'b1, 32'h40, 32'hB});
    read = 1'b1; addr = 32'h40;
    step();
    read = 1'b0;
    repeat (RD_LAT-1) step();
    rdata = 32'h1; clear = 1'b1;
    step();
    rdata = '0; clear = 1'b0;
    chk("t5_clr_pulse", err_pulse, 1);
    chk("t5_clr_cnts", {err_cnt, chk_cnt}, 0);
    chk("t5_clr_sticky", {err_sticky, err_got}, 0);
    chk("t5_full_kept", table_full, 1);

    // 6: reset with three reads in flight
    read = 1'b1; addr = 32'h40;
    step(); step(); step();
    read = 1'b0; rdata = 32'hDEAD;
    reset_n = 1'b0;
    #2;
    chk("t6_in_rst", {err_pulse, err_sticky, err_cnt, chk_cnt, table_full}, 0);
    step(); step();
    reset_n = 1'b1;
    repeat (4) step();
    rdata = '0;
    chk("t6_after_cnts", {err_pulse, err_cnt, chk_cnt}, 0);
    chk("t6_after_flags", {err_sticky, table_full}, 0);
    chk("t6_after_capture", {err_addr, err_exp, err_got}, 0);
    wr(32'h20, 32'h1234);
    rd(32'h20, 32'h1235, p);
    chk("t6_rerun", {p, err_sticky, err_cnt, chk_cnt}, {1'b1, 1'b1, 4'd1, 4'd1});
    chk("t6_rerun_cap", {err_addr, err_exp, err_got}, {32'h20, 32'h1234, 32'h1235});

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end
endmodule
